// File: rtl/usb2_tx_packet_sequencer_if.sv
// Link-side bundle of the USB2 TX packet sequencer: request/grant, payload source and PHY TX byte path.
// Signal names are from the sequencer's point of view (i_ = into the sequencer, o_ = out of it).
// slave = the sequencer itself, master = the endpoint logic / PHY side that faces it.
interface usb2_tx_packet_sequencer_if;
  logic       i_hs_req;
  logic [3:0] i_hs_pid;
  logic       o_hs_ack;
  logic       i_dat_req;
  logic [3:0] i_dat_pid;
  logic       i_dat_zlp;
  logic       o_dat_ack;
  logic [7:0] i_dat_byte;
  logic       i_dat_valid;
  logic       i_dat_last;
  logic       o_dat_ready;
  logic [7:0] o_tx_data;
  logic       o_tx_valid;
  logic       o_tx_start;
  logic       o_tx_end;
  logic       i_tx_ready;
  logic       o_busy;
  logic       o_done;
  logic       o_trunc;

  modport slave (
    input  i_hs_req, i_hs_pid, i_dat_req, i_dat_pid, i_dat_zlp,
    input  i_dat_byte, i_dat_valid, i_dat_last, i_tx_ready,
    output o_hs_ack, o_dat_ack, o_dat_ready,
    output o_tx_data, o_tx_valid, o_tx_start, o_tx_end,
    output o_busy, o_done, o_trunc
  );

  modport master (
    output i_hs_req, i_hs_pid, i_dat_req, i_dat_pid, i_dat_zlp,
    output i_dat_byte, i_dat_valid, i_dat_last, i_tx_ready,
    input  o_hs_ack, o_dat_ack, o_dat_ready,
    input  o_tx_data, o_tx_valid, o_tx_start, o_tx_end,
    input  o_busy, o_done, o_trunc
  );
endinterface

// File: rtl/usb2_tx_packet_sequencer.sv
// Purpose: arbitrates handshake vs data requests and emits SYNC, PID, payload, CRC16 to the PHY TX path.
// Latency: grant -> SYNC on next cycle; payload bytes pass through combinationally (byte/valid/ready).
// Backpressure: every byte waits for i_tx_ready; outputs hold while stalled. Optional macro USB2_TX_IPG_EN adds an inter-packet gap.
module usb2_tx_packet_sequencer #(
  parameter int MAX_BYTES  = 1024,
  parameter int IPG_CYCLES = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  usb2_tx_packet_sequencer_if.slave    io_bus
);

  localparam int CW = $clog2(MAX_BYTES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_PID,
    S_PAYLOAD,
    S_CRC_LO,
    S_CRC_HI,
    S_DONE
`ifdef USB2_TX_IPG_EN
    , S_GAP
`endif
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [3:0]      r_pid;
  logic            r_is_hs;
  logic            r_zlp;
  logic [15:0]     r_crc;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_inc;
  logic            w_grant_hs;
  logic            w_grant_dat;
  logic            w_pay_acc;
  logic [7:0]      w_tx_data;
  logic            w_tx_valid;
  logic            w_tx_start;
  logic            w_tx_end;
  logic            w_dat_ready;
  logic            w_done;
  logic            w_trunc;

`ifdef USB2_TX_IPG_EN
  localparam int GW = $clog2(IPG_CYCLES + 1);
  logic [GW-1:0]   r_gap;
`endif

  // Reflected CRC16 (0xA001) over one byte, LSB first.
  function automatic logic [15:0] f_crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc ^ {8'h00, b};
    for (int k = 0; k < 8; k++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  assign w_grant_hs  = (r_state == S_IDLE) && io_bus.i_hs_req;
  assign w_grant_dat = (r_state == S_IDLE) && !io_bus.i_hs_req && io_bus.i_dat_req;
  assign w_cnt_inc   = r_cnt + CW'(1);

  // Next-state and byte-path outputs; everything is a function of the current state and live handshakes.
  always_comb begin
    w_next      = r_state;
    w_tx_data   = 8'h00;
    w_tx_valid  = 1'b0;
    w_tx_start  = 1'b0;
    w_tx_end    = 1'b0;
    w_dat_ready = 1'b0;
    w_done      = 1'b0;
    w_trunc     = 1'b0;
    w_pay_acc   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant_hs || w_grant_dat) w_next = S_SYNC;
      end
      S_SYNC: begin
        w_tx_data  = 8'h80;
        w_tx_valid = 1'b1;
        w_tx_start = 1'b1;
        if (io_bus.i_tx_ready) w_next = S_PID;
      end
      S_PID: begin
        w_tx_data  = {~r_pid, r_pid};
        w_tx_valid = 1'b1;
        w_tx_end   = r_is_hs;
        if (io_bus.i_tx_ready) begin
          if (r_is_hs)    w_next = S_DONE;
          else if (r_zlp) w_next = S_CRC_LO;
          else            w_next = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        w_tx_data   = io_bus.i_dat_byte;
        w_tx_valid  = io_bus.i_dat_valid;
        w_dat_ready = io_bus.i_tx_ready;
        if (io_bus.i_dat_valid && io_bus.i_tx_ready) begin
          w_pay_acc = 1'b1;
          // A genuine last byte wins over the size limit, so a full-size packet is not flagged.
          if (io_bus.i_dat_last) begin
            w_next = S_CRC_LO;
          end else if (w_cnt_inc == CW'(MAX_BYTES)) begin
            w_next  = S_CRC_LO;
            w_trunc = 1'b1;
          end
        end
      end
      S_CRC_LO: begin
        w_tx_data  = ~r_crc[7:0];
        w_tx_valid = 1'b1;
        if (io_bus.i_tx_ready) w_next = S_CRC_HI;
      end
      S_CRC_HI: begin
        w_tx_data  = ~r_crc[15:8];
        w_tx_valid = 1'b1;
        w_tx_end   = 1'b1;
        if (io_bus.i_tx_ready) w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
`ifdef USB2_TX_IPG_EN
        w_next = S_GAP;
`else
        w_next = S_IDLE;
`endif
      end
`ifdef USB2_TX_IPG_EN
      S_GAP: begin
        if (r_gap == GW'(IPG_CYCLES - 1)) w_next = S_IDLE;
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  // State register; reset mid-packet drops straight to IDLE with no end marker.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Packet context latched at grant; CRC and byte count restart for every packet.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pid   <= 4'h0;
      r_is_hs <= 1'b0;
      r_zlp   <= 1'b0;
      r_crc   <= 16'hFFFF;
      r_cnt   <= '0;
    end else if (w_grant_hs || w_grant_dat) begin
      r_pid   <= w_grant_hs ? io_bus.i_hs_pid : io_bus.i_dat_pid;
      r_is_hs <= w_grant_hs;
      r_zlp   <= w_grant_dat && io_bus.i_dat_zlp;
      r_crc   <= 16'hFFFF;
      r_cnt   <= '0;
    end else if (w_pay_acc) begin
      r_crc   <= f_crc16_byte(r_crc, io_bus.i_dat_byte);
      r_cnt   <= w_cnt_inc;
    end
  end

`ifdef USB2_TX_IPG_EN
  // Gap counter restarts in DONE and runs while in GAP.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                  r_gap <= '0;
    else if (r_state == S_DONE) r_gap <= '0;
    else if (r_state == S_GAP)  r_gap <= r_gap + GW'(1);
  end
`endif

  assign io_bus.o_hs_ack    = w_grant_hs;
  assign io_bus.o_dat_ack   = w_grant_dat;
  assign io_bus.o_dat_ready = w_dat_ready;
  assign io_bus.o_tx_data   = w_tx_data;
  assign io_bus.o_tx_valid  = w_tx_valid;
  assign io_bus.o_tx_start  = w_tx_start;
  assign io_bus.o_tx_end    = w_tx_end;
  assign io_bus.o_busy      = (r_state != S_IDLE);
  assign io_bus.o_done      = w_done;
  assign io_bus.o_trunc     = w_trunc;

endmodule

// File: tb/tb_usb2_tx_packet_sequencer.sv
// Bench for usb2_tx_packet_sequencer: table of packet vectors plus hand-written arbitration and reset sequences.
// DUT built with MAX_BYTES = 8 so truncation is reachable; inputs driven 1 ns after posedge, outputs sampled on negedge.
// Optional macro USB2_TX_IPG_EN changes the expected spacing between back-to-back grants.
module tb_usb2_tx_packet_sequencer;

  localparam int MAXB = 8;
  localparam int IPG  = 16;
`ifdef USB2_TX_IPG_EN
  localparam int GAP_EXP = IPG + 1;
`else
  localparam int GAP_EXP = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  usb2_tx_packet_sequencer_if bus ();

  usb2_tx_packet_sequencer #(.MAX_BYTES(MAXB), .IPG_CYCLES(IPG)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(bus.slave)
  );

  typedef struct {
    bit             hs;
    logic [3:0]     pid;
    bit             zlp;
    int             n;
    int             last_at;
    bit             rdy_all;
    logic [9:0][7:0] b;
    int             exp_pay;
    int             exp_trunc;
  } vec_t;

  vec_t vt[7];

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] cap_d[$];
  logic       cap_s[$];
  logic       cap_e[$];
  int n_hs_ack, n_dat_ack, n_done, n_trunc, n_rdy, n_stall_viol;
  int cyc, hs_ack_cyc, dat_ack_cyc, done_cyc;
  logic       p_stall;
  logic [9:0] p_out;
  logic [7:0] src_b[10];
  int src_n, src_i, src_last;
  bit rdy_all, src_hold, got_hs, got_dat;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [17:0] outs();
    return {bus.o_hs_ack, bus.o_dat_ack, bus.o_dat_ready, bus.o_tx_data, bus.o_tx_valid,
            bus.o_tx_start, bus.o_tx_end, bus.o_busy, bus.o_done, bus.o_trunc};
  endfunction

  // Bit-serial reference of the USB CRC16 shift register (LSB first).
  function automatic logic [15:0] m_crc(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    logic fb;
    r = c;
    for (int k = 0; k < 8; k++) begin
      fb = r[0] ^ b[k];
      r  = r >> 1;
      if (fb) r = r ^ 16'hA001;
    end
    return r;
  endfunction

  function automatic vec_t mk(input bit hs, input logic [3:0] pid, input bit zlp, input int n,
                              input int last_at, input bit ra, input int exp_pay, input int exp_trunc);
    vec_t v;
    v.hs = hs; v.pid = pid; v.zlp = zlp; v.n = n; v.last_at = last_at; v.rdy_all = ra;
    v.b = '0; v.exp_pay = exp_pay; v.exp_trunc = exp_trunc;
    return v;
  endfunction

  task automatic clear_mon();
    cap_d.delete(); cap_s.delete(); cap_e.delete();
    n_hs_ack = 0; n_dat_ack = 0; n_done = 0; n_trunc = 0; n_rdy = 0; n_stall_viol = 0;
    cyc = 0; hs_ack_cyc = -1; dat_ack_cyc = -1; done_cyc = -1;
    p_stall = 1'b0; p_out = '0; src_i = 0; src_hold = 1'b0; got_hs = 1'b0; got_dat = 1'b0;
  endtask

  task automatic drive();
    bus.i_tx_ready = rdy_all ? 1'b1 : ($urandom_range(0, 2) != 0);
    if (src_i < src_n) begin
      bus.i_dat_byte  = src_b[src_i];
      bus.i_dat_valid = src_hold || rdy_all || ($urandom_range(0, 3) != 0);
      bus.i_dat_last  = (src_i == src_last);
    end else begin
      bus.i_dat_byte  = 8'h00;
      bus.i_dat_valid = 1'b0;
      bus.i_dat_last  = 1'b0;
    end
  endtask

  task automatic sample();
    cyc++;
    if (p_stall && ({bus.o_tx_data, bus.o_tx_start, bus.o_tx_end} !== p_out)) n_stall_viol++;
    p_stall = bus.o_tx_valid && !bus.i_tx_ready;
    p_out   = {bus.o_tx_data, bus.o_tx_start, bus.o_tx_end};
    if (bus.o_tx_valid && bus.i_tx_ready) begin
      cap_d.push_back(bus.o_tx_data);
      cap_s.push_back(bus.o_tx_start);
      cap_e.push_back(bus.o_tx_end);
    end
    if (bus.o_hs_ack)  begin n_hs_ack++;  hs_ack_cyc = cyc;  got_hs = 1'b1; end
    if (bus.o_dat_ack) begin n_dat_ack++; dat_ack_cyc = cyc; got_dat = 1'b1; end
    if (bus.o_done) begin n_done++; if (done_cyc < 0) done_cyc = cyc; end
    if (bus.o_trunc) n_trunc++;
    if (bus.o_dat_ready) n_rdy++;
    if (bus.i_dat_valid && bus.o_dat_ready) src_i++;
    src_hold = bus.i_dat_valid && !bus.o_dat_ready;
  endtask

  // One clock: drive, sample on negedge, release acknowledged requests after the edge.
  task automatic one_cycle();
    drive();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    if (got_hs)  bus.i_hs_req  = 1'b0;
    if (got_dat) bus.i_dat_req = 1'b0;
  endtask

  task automatic run_until_done(input string nm, input int want);
    bit fin;
    fin = 1'b0;
    for (int c = 0; c < 400 && !fin; c++) begin
      one_cycle();
      if (n_done >= want) fin = 1'b1;
    end
    if (!fin) chk({nm, " timeout waiting for o_done"}, n_done, want);
    src_n = 0; rdy_all = 1'b1;
    repeat (3) one_cycle();
  endtask

  task automatic check_stream(input string nm, input logic [7:0] exp[$], input bit st[$], input bit en[$]);
    chk({nm, " byte count"}, cap_d.size(), exp.size());
    for (int k = 0; k < exp.size() && k < cap_d.size(); k++)
      chk($sformatf("%s byte%0d {start,end,data}", nm, k), {cap_s[k], cap_e[k], cap_d[k]}, {st[k], en[k], exp[k]});
  endtask

  task automatic run_vec(input int id, input int abort_after);
    vec_t v;
    logic [7:0] exp[$];
    bit st[$], en[$];
    logic [15:0] crc;
    string nm;
    v  = vt[id];
    nm = $sformatf("v%0d", id);
    clear_mon();
    for (int k = 0; k < 10; k++) src_b[k] = v.b[k];
    src_n = (v.hs || v.zlp) ? 0 : v.n;
    src_last = v.last_at;
    rdy_all = v.rdy_all;
    bus.i_hs_pid = v.pid; bus.i_dat_pid = v.pid; bus.i_dat_zlp = v.zlp;
    bus.i_hs_req = v.hs;  bus.i_dat_req = !v.hs;
    if (abort_after > 0) begin
      for (int c = 0; c < 100 && cap_d.size() < abort_after; c++) one_cycle();
      chk("abort busy before reset", bus.o_busy, 1'b1);
      rst = 1'b1;
      #1;
      chk("abort outputs zero during reset", outs(), 18'h0);
      chk("abort no end issued", cap_e.sum() with (int'(item)), 0);
      src_n = 0; drive();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      return;
    end
    run_until_done(nm, 1);
    exp.push_back(8'h80); st.push_back(1'b1); en.push_back(1'b0);
    exp.push_back({~v.pid, v.pid}); st.push_back(1'b0); en.push_back(v.hs);
    if (!v.hs) begin
      crc = 16'hFFFF;
      for (int k = 0; k < v.exp_pay; k++) begin
        exp.push_back(v.b[k]); st.push_back(1'b0); en.push_back(1'b0);
        crc = m_crc(crc, v.b[k]);
      end
      exp.push_back(~crc[7:0]);  st.push_back(1'b0); en.push_back(1'b0);
      exp.push_back(~crc[15:8]); st.push_back(1'b0); en.push_back(1'b1);
      crc = 16'hFFFF;
      for (int k = 2; k < cap_d.size(); k++) crc = m_crc(crc, cap_d[k]);
      chk({nm, " crc residual"}, crc, 16'hB001);
    end
    check_stream(nm, exp, st, en);
    chk({nm, " acks {hs,dat}"}, {n_hs_ack[7:0], n_dat_ack[7:0]}, v.hs ? 16'h0100 : 16'h0001);
    chk({nm, " done pulses"}, n_done, 1);
    chk({nm, " trunc pulses"}, n_trunc, v.exp_trunc);
    chk({nm, " stall stability violations"}, n_stall_viol, 0);
    if (v.hs || v.zlp) chk({nm, " dat_ready cycles"}, n_rdy, 0);
    chk({nm, " idle outputs after packet"}, outs(), 18'h0);
  endtask

  initial begin
    logic [7:0] e2[$];
    bit s2[$], n2[$];

    vt[0] = mk(1, 4'h2, 0, 0, -1, 1, 0, 0);
    vt[1] = mk(1, 4'hA, 0, 0, -1, 0, 0, 0);
    vt[2] = mk(0, 4'h3, 1, 0, -1, 1, 0, 0);
    vt[3] = mk(0, 4'hB, 0, 4, 3, 0, 4, 0);
    for (int k = 0; k < 4; k++) vt[3].b[k] = 8'($urandom);
    vt[4] = mk(0, 4'h3, 0, 1, 0, 1, 1, 0);
    vt[4].b[0] = 8'hA5;
    vt[5] = mk(0, 4'hB, 0, 10, -1, 0, 8, 1);
    for (int k = 0; k < 10; k++) vt[5].b[k] = 8'(k * 17 + 1);
    vt[6] = mk(0, 4'hF, 0, 8, 7, 1, 8, 0);
    for (int k = 0; k < 8; k++) vt[6].b[k] = 8'hF0 ^ 8'(k);

    bus.i_hs_req = 0; bus.i_hs_pid = 0; bus.i_dat_req = 0; bus.i_dat_pid = 0; bus.i_dat_zlp = 0;
    bus.i_dat_byte = 0; bus.i_dat_valid = 0; bus.i_dat_last = 0; bus.i_tx_ready = 0;
    rst = 1'b1;
    #2;
    chk("reset outputs zero", outs(), 18'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("post-reset idle outputs", outs(), 18'h0);

    for (int i = 0; i < 7; i++) run_vec(i, 0);

    // Both requests together: handshake first, data follows after the idle/gap spacing.
    clear_mon();
    src_n = 0; rdy_all = 1'b1;
    bus.i_hs_pid = 4'h2; bus.i_dat_pid = 4'h3; bus.i_dat_zlp = 1'b1;
    bus.i_hs_req = 1'b1; bus.i_dat_req = 1'b1;
    run_until_done("arb", 2);
    e2 = '{8'h80, 8'hD2, 8'h80, 8'hC3, 8'h00, 8'h00};
    s2 = '{1, 0, 1, 0, 0, 0};
    n2 = '{0, 1, 0, 0, 0, 1};
    check_stream("arb", e2, s2, n2);
    chk("arb hs granted before dat", (hs_ack_cyc >= 0) && (hs_ack_cyc < dat_ack_cyc), 1'b1);
    chk("arb done->next grant spacing", dat_ack_cyc - done_cyc, GAP_EXP);
    chk("arb done pulses", n_done, 2);

    // Reset in the middle of payload byte 3, then a clean ACK packet.
    vt[4] = mk(0, 4'hB, 0, 6, 5, 1, 6, 0);
    for (int k = 0; k < 6; k++) vt[4].b[k] = 8'(8'h30 + k);
    run_vec(4, 5);
    run_vec(0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/usb2_tx_packet_sequencer.md
Name: usb2_tx_packet_sequencer

Overview:
Arbitrates between a handshake requester and a data-endpoint requester and sequences one complete USB packet into the PHY transmit path: SYNC byte, PID byte, optional payload, and CRC16. It drives the byte/valid/start/end interface of the serialiser / bit-stuffer / NRZI chain and honours its ready back-pressure. It sits between the link-layer endpoint logic and the PHY transmit datapath.

Parameters:
MAX_BYTES, 1024, maximum payload bytes per data packet; reaching it without i_dat_last forces packet termination.
IPG_CYCLES, 16, inter-packet gap in i_clk cycles (used only with the optional feature).

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous reset, active-high
i_hs_req  in  1  handshake packet request, level, held until o_hs_ack
i_hs_pid  in  4  handshake PID (ACK/NAK/STALL/NYET)
o_hs_ack  out  1  1-cycle pulse when the handshake request is granted
i_dat_req  in  1  data packet request, level, held until o_dat_ack
i_dat_pid  in  4  data PID (DATA0/1/2/MDATA)
i_dat_zlp  in  1  zero-length packet; sampled at grant
o_dat_ack  out  1  1-cycle pulse when the data request is granted
i_dat_byte  in  8  payload byte
i_dat_valid  in  1  payload byte valid
i_dat_last  in  1  qualifies the final payload byte
o_dat_ready  out  1  payload byte consumed when i_dat_valid && o_dat_ready
o_tx_data  out  8  byte to the transmit path
o_tx_valid  out  1  o_tx_data valid
o_tx_start  out  1  high with the SYNC byte
o_tx_end  out  1  high with the final byte of the packet
i_tx_ready  in  1  transmit path accepts a byte when o_tx_valid && i_tx_ready
o_busy  out  1  high from grant until return to IDLE
o_done  out  1  1-cycle pulse when the final byte is accepted
o_trunc  out  1  1-cycle pulse when a payload is truncated at MAX_BYTES

Behaviour:
- Reset: all outputs are 0, state IDLE, CRC register 0xFFFF, byte counter 0. An assertion of i_rst mid-packet aborts immediately; no o_tx_end is issued.
- Transfer rule: a byte advances only on o_tx_valid && i_tx_ready. While the transmit path is stalled, o_tx_data, o_tx_start and o_tx_end hold stable.
- Arbitration (IDLE only): i_hs_req has priority over i_dat_req. On the grant cycle the block pulses the matching ack, latches the PID (and i_dat_zlp), and moves to SYNC the next cycle. A request arriving mid-packet waits; a packet is never pre-empted.
- States:
  - IDLE
  - SYNC: o_tx_data = 0x80, o_tx_start = 1.
  - PID: o_tx_data = {~pid, pid}. For a handshake packet o_tx_end = 1, then DONE. For a data packet the next state is CRC_LO if zlp, else PAYLOAD.
  - PAYLOAD: o_tx_data = i_dat_byte, o_tx_valid = i_dat_valid, o_dat_ready = i_tx_ready. Each accepted byte updates the CRC and increments the counter. Move to CRC_LO when the accepted byte has i_dat_last, or when the counter reaches MAX_BYTES; the second case also pulses o_trunc.
  - CRC_LO: o_tx_data = ~crc[7:0].
  - CRC_HI: o_tx_data = ~crc[15:8], o_tx_end = 1.
  - DONE: o_done pulses, then IDLE (or GAP with the optional feature).
- CRC16: polynomial x^16+x^15+x^2+1, processed LSB-first (reflected form 0xA001), initial value 0xFFFF, transmitted complemented, low byte first. PID and SYNC bytes are excluded. The CRC and counter reset on every grant.
- An input bubble (i_dat_valid = 0) in PAYLOAD holds o_tx_valid low; no underrun detection is performed.
- Back-to-back packets: minimum of one IDLE cycle between DONE and the next grant.

Optional Feature:
USB2_TX_IPG_EN:
- Defined: DONE goes to GAP, which counts IPG_CYCLES cycles with all tx outputs low and no grants, then goes to IDLE. o_busy stays high in GAP.
- Undefined: no GAP state; DONE goes directly to IDLE.

Test Plan:
- Handshake ACK (pid 0x2), i_tx_ready = 1: o_hs_ack pulses; stream is 0x80 (start=1), then 0xD2 (end=1); o_done pulses once.
- Data DATA0 (pid 0x3), zlp = 1: stream is 0x80, 0xC3, 0x00, 0x00 with end on the last byte; o_dat_ready never asserted.
- DATA1 with 4 random bytes and random i_tx_ready/i_dat_valid stalls: the byte sequence matches the reference model, and a CRC16 check over payload + 2 CRC bytes yields residual 0xB001 (reflected); outputs stay stable while stalled.
- i_hs_req and i_dat_req asserted together: handshake sent first; data packet follows after IDLE with correct SYNC/PID.
- MAX_BYTES = 8, 10-byte stream without last: 8 bytes sent, o_trunc pulses, CRC of the 8 bytes is appended, o_tx_end on CRC_HI.
- i_rst asserted during PAYLOAD byte 3: all outputs go to 0 asynchronously; after release, a new ACK request produces a clean 0x80, 0xD2 packet. With USB2_TX_IPG_EN, a back-to-back request is granted no earlier than IPG_CYCLES + 1 cycles after o_done.
